// File: rtl/data_store_queue_if.sv
// Store-request, operand-read and flush handshake bundle for data_store_queue.
// master = execute/write-back side driving stores and reads, slave = the queue.
interface data_store_queue_if #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
);
    logic                    wr_valid;
    logic                    wr_ready;
    logic [ADDR_WIDTH-1:0]   wr_address;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    mem_hold;
    logic [ADDR_WIDTH-1:0]   rd_address;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    flush;
    logic                    flush_done;
    logic [$clog2(DEPTH):0]  pending;

    modport master (
        output wr_valid, wr_address, wr_data, mem_hold, rd_address, flush,
        input  wr_ready, rd_data, flush_done, pending
    );

    modport slave (
        input  wr_valid, wr_address, wr_data, mem_hold, rd_address, flush,
        output wr_ready, rd_data, flush_done, pending
    );
endinterface

// File: rtl/data_store_queue.sv
// In-order store queue retiring into a word-addressed data memory, with forwarded reads and flush drain.
// Optional macro DATA_STORE_PRELOAD_EN: reset loads the boot operand image instead of zeros.
module data_store_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    data_store_queue_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WORDS = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

`ifdef DATA_STORE_PRELOAD_EN
    function automatic logic [DATA_WIDTH-1:0] f_boot_word(input int unsigned idx);
        case (idx)
            0:       return DATA_WIDTH'(16'h000A);
            1:       return DATA_WIDTH'(16'h000F);
            2:       return DATA_WIDTH'(16'h0010);
            3:       return DATA_WIDTH'(16'h0008);
            4:       return DATA_WIDTH'(16'h00FF);
            5:       return DATA_WIDTH'(16'h000F);
            6:       return DATA_WIDTH'(16'h000A);
            default: return '0;
        endcase
    endfunction
`endif

    logic [ADDR_WIDTH-1:0] r_q_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_q_data [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem    [WORDS];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    state_t                r_state;
    logic                  r_flush_done;

    logic                  w_wr_ready;
    logic                  w_accept;
    logic                  w_retire;
    logic [PTR_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Readiness comes from registered state only, so a same-edge retire never admits an extra store.
    assign w_wr_ready = (r_state == ST_RUN) && (r_count < CNT_W'(DEPTH));
    assign w_accept   = bus.wr_valid && w_wr_ready;
    assign w_retire   = (r_count != '0) && !bus.mem_hold;

    // Entry storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_q_addr[r_tail] <= bus.wr_address;
            r_q_data[r_tail] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_state      <= ST_RUN;
            r_flush_done <= 1'b0;
            for (int unsigned i = 0; i < WORDS; i++) begin
`ifdef DATA_STORE_PRELOAD_EN
                r_mem[i] <= f_boot_word(i);
`else
                r_mem[i] <= '0;
`endif
            end
        end else begin
            if (w_accept) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_retire) begin
                r_mem[r_q_addr[r_head]] <= r_q_data[r_head];
                r_head                  <= r_head + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_retire);

            // flush_done is raised one edge after entering DONE and only while flush is still held.
            case (r_state)
                ST_RUN: begin
                    r_flush_done <= 1'b0;
                    if (bus.flush) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_flush_done <= 1'b0;
                    if (r_count == '0) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.flush) begin
                        r_flush_done <= 1'b1;
                    end else begin
                        r_flush_done <= 1'b0;
                        r_state      <= ST_RUN;
                    end
                end
                default: begin
                    r_flush_done <= 1'b0;
                    r_state      <= ST_RUN;
                end
            endcase
        end
    end

    // Walk oldest to youngest so the last match, the youngest store, wins.
    always_comb begin
        w_rd_data = r_mem[bus.rd_address];
        w_idx     = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PTR_W'(k);
            if ((CNT_W'(k) < r_count) && (r_q_addr[w_idx] == bus.rd_address)) begin
                w_rd_data = r_q_data[w_idx];
            end
        end
    end

    assign bus.wr_ready   = w_wr_ready;
    assign bus.rd_data    = w_rd_data;
    assign bus.flush_done = r_flush_done;
    assign bus.pending    = r_count;
endmodule

// File: tb/tb_data_store_queue.sv
// Directed bench for data_store_queue: vector table plus flush, reset and wrap-around sequences.
// Honours DATA_STORE_PRELOAD_EN for expected reset memory contents.
module tb_data_store_queue;
    logic clk;
    logic reset;
    int unsigned errors;
    int unsigned checks;
    logic [15:0] img [16];
    logic [15:0] mmem [16];
    logic [3:0]  mq_a [$];
    logic [15:0] mq_d [$];

    typedef struct {
        logic        wv;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        hold;
        logic [3:0]  ra;
        logic [2:0]  p;
        logic        rdy;
        logic [15:0] rd;
        logic        fd;
    } vec_t;
    vec_t vt [21];

    data_store_queue_if #(.DEPTH(4), .ADDR_WIDTH(4), .DATA_WIDTH(16)) bus ();

    data_store_queue #(.DEPTH(4), .ADDR_WIDTH(4), .DATA_WIDTH(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [3:0] wa, input logic [15:0] wd,
                         input logic hold, input logic [3:0] ra, input logic fl);
        bus.wr_valid   = wv;
        bus.wr_address = wa;
        bus.wr_data    = wd;
        bus.mem_hold   = hold;
        bus.rd_address = ra;
        bus.flush      = fl;
    endtask

    task automatic do_reset();
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) mmem[i] = img[i];
        mq_a.delete();
        mq_d.delete();
    endtask

    task automatic check_memory(input string name);
        for (int i = 0; i < 16; i++) begin
            bus.rd_address = 4'(i);
            #1;
            chk(name, bus.rd_data, mmem[i]);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [3:0] ra);
        logic [15:0] r;
        r = mmem[ra];
        for (int i = 0; i < mq_a.size(); i++) begin
            if (mq_a[i] == ra) r = mq_d[i];
        end
        return r;
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 16; i++) img[i] = 16'h0000;
`ifdef DATA_STORE_PRELOAD_EN
        img[0] = 16'h000A; img[1] = 16'h000F; img[2] = 16'h0010; img[3] = 16'h0008;
        img[4] = 16'h00FF; img[5] = 16'h000F; img[6] = 16'h000A;
`endif

        // wv wa data hold ra | pending ready rd_data flush_done (post-edge)
        vt[0]  = '{1'b1, 4'd3, 16'h1234, 1'b0, 4'd3, 3'd1, 1'b1, 16'h1234, 1'b0};
        vt[1]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd3, 3'd0, 1'b1, 16'h1234, 1'b0};
        vt[2]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd7, 3'd0, 1'b1, 16'h0000, 1'b0};
        vt[3]  = '{1'b1, 4'd0, 16'h00A0, 1'b1, 4'd8, 3'd1, 1'b1, 16'h0000, 1'b0};
        vt[4]  = '{1'b1, 4'd1, 16'h00A1, 1'b1, 4'd8, 3'd2, 1'b1, 16'h0000, 1'b0};
        vt[5]  = '{1'b1, 4'd2, 16'h00A2, 1'b1, 4'd2, 3'd3, 1'b1, 16'h00A2, 1'b0};
        vt[6]  = '{1'b1, 4'd3, 16'h00A3, 1'b1, 4'd2, 3'd4, 1'b0, 16'h00A2, 1'b0};
        vt[7]  = '{1'b1, 4'd2, 16'hFFFF, 1'b1, 4'd2, 3'd4, 1'b0, 16'h00A2, 1'b0};
        vt[8]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd3, 3'd3, 1'b1, 16'h00A3, 1'b0};
        vt[9]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 3'd2, 1'b1, 16'h00A0, 1'b0};
        vt[10] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd1, 3'd1, 1'b1, 16'h00A1, 1'b0};
        vt[11] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd3, 3'd0, 1'b1, 16'h00A3, 1'b0};
        vt[12] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd2, 3'd0, 1'b1, 16'h00A2, 1'b0};
        vt[13] = '{1'b1, 4'd5, 16'h1111, 1'b1, 4'd5, 3'd1, 1'b1, 16'h1111, 1'b0};
        vt[14] = '{1'b1, 4'd5, 16'h2222, 1'b1, 4'd5, 3'd2, 1'b1, 16'h2222, 1'b0};
        vt[15] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 3'd2, 1'b1, 16'h2222, 1'b0};
        vt[16] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd5, 3'd1, 1'b1, 16'h2222, 1'b0};
        vt[17] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd5, 3'd0, 1'b1, 16'h2222, 1'b0};
        vt[18] = '{1'b1, 4'd6, 16'h0606, 1'b0, 4'd6, 3'd1, 1'b1, 16'h0606, 1'b0};
        vt[19] = '{1'b1, 4'd7, 16'h0707, 1'b0, 4'd6, 3'd1, 1'b1, 16'h0606, 1'b0};
        vt[20] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd7, 3'd0, 1'b1, 16'h0707, 1'b0};

        // Reset state, checked while reset is still asserted.
        reset = 1'b1;
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd4, 1'b0);
        #2;
        chk("reset_pending", bus.pending, 0);
        chk("reset_ready", bus.wr_ready, 1);
        chk("reset_flush_done", bus.flush_done, 0);
        chk("reset_word4", bus.rd_data, img[4]);
        tick();
        reset = 1'b0;

        foreach (vt[i]) begin
            drive(vt[i].wv, vt[i].wa, vt[i].wd, vt[i].hold, vt[i].ra, 1'b0);
            tick();
            chk($sformatf("vec%0d_pending", i), bus.pending, vt[i].p);
            chk($sformatf("vec%0d_ready", i), bus.wr_ready, vt[i].rdy);
            chk($sformatf("vec%0d_rd_data", i), bus.rd_data, vt[i].rd);
            chk($sformatf("vec%0d_flush_done", i), bus.flush_done, vt[i].fd);
        end

        // Simultaneous accept/retire across pointer wrap against a queue model.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            logic wv, hold, acc, ret;
            logic [3:0] wa, ra;
            logic [15:0] wd;
            wv   = (i % 3) != 2;
            hold = (i % 4) == 1;
            wa   = 4'((i * 5) % 16);
            ra   = 4'((i * 5 + 11) % 16);
            wd   = 16'(16'h3000 + i);
            drive(wv, wa, wd, hold, ra, 1'b0);
            #1;
            chk("alt_ready_pre", bus.wr_ready, mq_a.size() < 4);
            acc = wv && (mq_a.size() < 4);
            ret = (mq_a.size() > 0) && !hold;
            if (ret) begin
                mmem[mq_a[0]] = mq_d[0];
                void'(mq_a.pop_front());
                void'(mq_d.pop_front());
            end
            if (acc) begin
                mq_a.push_back(wa);
                mq_d.push_back(wd);
            end
            tick();
            chk($sformatf("alt%0d_pending", i), bus.pending, mq_a.size());
            chk($sformatf("alt%0d_rd_data", i), bus.rd_data, model_read(ra));
        end
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        while (mq_a.size() > 0) begin
            mmem[mq_a[0]] = mq_d[0];
            void'(mq_a.pop_front());
            void'(mq_d.pop_front());
        end
        chk("alt_drained", bus.pending, 0);
        check_memory("alt_memory");

        // Flush with three stores held back by mem_hold, a fourth accepted on the flush edge.
        do_reset();
        drive(1'b1, 4'd8,  16'h0801, 1'b1, 4'd8, 1'b0); tick();
        drive(1'b1, 4'd9,  16'h0902, 1'b1, 4'd8, 1'b0); tick();
        drive(1'b1, 4'd10, 16'h0A03, 1'b1, 4'd8, 1'b0); tick();
        chk("fl_pending3", bus.pending, 3);
        drive(1'b1, 4'd11, 16'h0B04, 1'b1, 4'd11, 1'b1); tick();
        chk("fl_pending4", bus.pending, 4);
        chk("fl_ready_low", bus.wr_ready, 0);
        chk("fl_rd_fwd", bus.rd_data, 16'h0B04);
        drive(1'b1, 4'd12, 16'hDEAD, 1'b1, 4'd12, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("fl_hold_pending", bus.pending, 4);
            chk("fl_hold_done", bus.flush_done, 0);
        end
        bus.mem_hold = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            tick();
            chk("fl_drain_pending", bus.pending, i);
            chk("fl_drain_done", bus.flush_done, 0);
            chk("fl_drain_ready", bus.wr_ready, 0);
        end
        tick();
        chk("fl_done_lag", bus.flush_done, 0);
        tick();
        chk("fl_done", bus.flush_done, 1);
        chk("fl_done_ready", bus.wr_ready, 0);
        mmem[8] = 16'h0801; mmem[9] = 16'h0902; mmem[10] = 16'h0A03; mmem[11] = 16'h0B04;
        check_memory("fl_memory");
        bus.wr_valid = 1'b0;
        bus.flush    = 1'b0;
        tick();
        chk("fl_release_ready", bus.wr_ready, 1);
        chk("fl_release_done", bus.flush_done, 0);

        // Flush of an empty queue: flush_done two edges after the sampling edge.
        bus.flush = 1'b1;
        tick();
        chk("ef_n_done", bus.flush_done, 0);
        chk("ef_n_ready", bus.wr_ready, 0);
        tick();
        chk("ef_n1_done", bus.flush_done, 0);
        tick();
        chk("ef_n2_done", bus.flush_done, 1);
        bus.flush = 1'b0;
        tick();
        chk("ef_release_done", bus.flush_done, 0);
        chk("ef_release_ready", bus.wr_ready, 1);

        // Reset with three stores pending discards them.
        drive(1'b1, 4'd4, 16'hBEEF, 1'b1, 4'd4, 1'b0); tick();
        drive(1'b1, 4'd5, 16'hCAFE, 1'b1, 4'd4, 1'b0); tick();
        drive(1'b1, 4'd0, 16'h1357, 1'b1, 4'd4, 1'b0); tick();
        chk("rst_pre_pending", bus.pending, 3);
        chk("rst_pre_fwd", bus.rd_data, 16'hBEEF);
        bus.wr_valid = 1'b0;
        reset = 1'b1;
        #2;
        chk("rst_async_pending", bus.pending, 0);
        chk("rst_async_done", bus.flush_done, 0);
        chk("rst_async_word4", bus.rd_data, img[4]);
        tick();
        reset = 1'b0;
        bus.mem_hold = 1'b0;
        tick();
        chk("rst_post_pending", bus.pending, 0);
        for (int i = 0; i < 16; i++) mmem[i] = img[i];
        check_memory("rst_memory");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
